// File: rtl/wb_master_seq.sv
// -----------------------------------------------------------------------------
// wb_master_seq
// Single-outstanding Wishbone classic master. Turns one command handshake
// into exactly one Wishbone cycle and returns the result through a response
// handshake. A wait counter bounds every cycle: if the slave does not
// acknowledge within TIMEOUT cycles, the cycle is dropped and an error
// response carrying ERR_DATA is returned.
//
// Parameters
//   TIMEOUT   maximum number of bus cycles stb stays high (2..255)
//   ERR_DATA  rsp_dat value returned on a timed-out transaction
//
// Ports
//   wb_clk_i, wb_rst_ni          clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_we/adr/dat/sel           command fields (1 = write)
//   rsp_valid/rsp_ready          response handshake
//   rsp_dat, rsp_err             read data (0 for writes, ERR_DATA on timeout)
//   wbm_cyc_o .. wbm_dat_o       Wishbone master outputs (all registered)
//   wbm_dat_i, wbm_ack_i         Wishbone slave read data and acknowledge
// -----------------------------------------------------------------------------
module wb_master_seq #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter value on the last allowed wait cycle; the counter starts at 0 on
  // the accept edge, so stb is high for exactly TIMEOUT cycles on a timeout.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 32'd1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_dat;
  logic        r_rsp_err;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat_o;

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat_o;

  // Transaction sequencer: state, wait counter and every registered output.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'd0;
      r_adr       <= 32'd0;
      r_dat_o     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_we        <= cmd_we;
            r_adr       <= cmd_adr;
            r_dat_o     <= cmd_dat;
            r_sel       <= cmd_sel;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_cnt       <= 8'd0;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_BUS;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_BUS: begin
          // Ack is checked first so an ack on the final wait cycle wins.
          if (wbm_ack_i) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_rsp_dat <= r_we ? 32'd0 : wbm_dat_i;
            r_rsp_err <= 1'b0;
            r_state   <= ST_RESP;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_rsp_dat <= ERR_DATA;
            r_rsp_err <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          // rsp_valid rises one edge after entering RESP; the handshake is
          // only honoured once it is visible to the consumer.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
module tb_wb_master_seq;

  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'd0;
  logic [31:0] cmd_dat = 32'd0;
  logic [3:0]  cmd_sel = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'd0;
  logic        wbm_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  wb_master_seq #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a slave acking on wait cycle k (1-based) completes if k lies
  // within the TIMEOUT window; otherwise the transaction times out after
  // TMO strobe cycles. The response appears one edge after stb drops.
  function automatic void model(input logic we, input int ack_at, input logic [31:0] rdata,
                                output int exp_stb, output int exp_lat,
                                output logic [31:0] exp_dat, output logic exp_err);
    if (ack_at >= 1 && ack_at <= TMO) begin
      exp_stb = ack_at;
      exp_err = 1'b0;
      exp_dat = we ? 32'd0 : rdata;
    end else begin
      exp_stb = TMO;
      exp_err = 1'b1;
      exp_dat = ERR;
    end
    exp_lat = exp_stb + 1;
  endfunction

  // Runs one command through to a consumed response and reports what was seen.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                        input int rsp_delay, input bit noisy,
                        output int o_stb, output int o_lat, output logic [31:0] o_dat,
                        output logic o_err, output bit o_acc, output bit o_hold, output bit o_to);
    int  e;
    bit  seen;
    o_stb = 0; o_lat = 0; o_hold = 1'b1; o_to = 1'b0; o_dat = 32'd0; o_err = 1'b0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    tick();
    o_acc = (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1 && cmd_ready === 1'b0);
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    e = 0; seen = 1'b0;
    while (!seen && e < 400) begin
      if (wbm_stb_o === 1'b1) begin
        o_stb++;
        if (wbm_cyc_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
            wbm_dat_o !== dat || wbm_sel_o !== sel || cmd_ready !== 1'b0)
          o_hold = 1'b0;
        wbm_ack_i = (o_stb == ack_at);
        wbm_dat_i = (o_stb == ack_at) ? rdata : $urandom;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
      end
      tick();
      e++;
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        o_lat = e;
      end
    end
    wbm_ack_i = 1'b0;
    if (!seen) begin
      o_to = 1'b1;
    end else begin
      o_dat = rsp_dat;
      o_err = rsp_err;
      for (int i = 0; i < rsp_delay; i++) begin
        if (noisy) begin
          cmd_valid = 1'b1;
          cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
          wbm_ack_i = (i == 3);
          wbm_dat_i = $urandom;
        end
        tick();
        if (rsp_valid !== 1'b1 || rsp_dat !== o_dat || rsp_err !== o_err ||
            cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0)
          o_hold = 1'b0;
      end
      wbm_ack_i = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      // No accept on the consume edge; bus fields keep their last values.
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 ||
          cmd_ready !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
          wbm_dat_o !== dat || wbm_sel_o !== sel)
        o_hold = 1'b0;
    end
  endtask

  task automatic check_txn(input string name, input logic we, input int ack_at,
                           input logic [31:0] rdata, input int stb, input int lat,
                           input logic [31:0] dat, input logic err, input bit acc,
                           input bit hold, input bit to);
    int          es, el;
    logic [31:0] ed;
    logic        ee;
    model(we, ack_at, rdata, es, el, ed, ee);
    checks++;
    if (to !== 1'b0 || acc !== 1'b1 || hold !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: timeout=%0b accepted=%0b hold=%0b, required 0/1/1", name, to, acc, hold);
    end
    checks++;
    if (stb !== es) begin
      errors++;
      $display("FAIL %s stb_cycles: got %0d, required %0d", name, stb, es);
    end
    checks++;
    if (lat !== el) begin
      errors++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, el);
    end
    checks++;
    if (dat !== ed || err !== ee) begin
      errors++;
      $display("FAIL %s response: got %h/%0b, required %h/%0b", name, dat, err, ed, ee);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'd0 ||
        wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_dat !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: cyc=%0b stb=%0b we=%0b sel=%h adr=%h dat=%h rv=%0b re=%0b rd=%h, required all 0",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_err, rsp_dat);
    end
    #10;
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %0b, required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int s, l; logic [31:0] d; logic r; bit a, h, t;
    do_txn(1'b1, 32'h3000_0008, 32'hC0A8_0001, 4'hF, 2, 32'h1234_5678, 0, 1'b0, s, l, d, r, a, h, t);
    check_txn("write_ack2", 1'b1, 2, 32'h1234_5678, s, l, d, r, a, h, t);
  endtask

  task automatic test_read();
    int s, l; logic [31:0] d; logic r; bit a, h, t;
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 32'hC0A8_0001, 1, 1'b0, s, l, d, r, a, h, t);
    check_txn("read_ack1", 1'b0, 1, 32'hC0A8_0001, s, l, d, r, a, h, t);
  endtask

  task automatic test_timeout();
    int s, l; logic [31:0] d; logic r; bit a, h, t;
    do_txn(1'b0, 32'hF000_0000, 32'h0, 4'hF, 0, 32'h0, 2, 1'b0, s, l, d, r, a, h, t);
    check_txn("timeout", 1'b0, 0, 32'h0, s, l, d, r, a, h, t);
  endtask

  task automatic test_ack_at_limit();
    int s, l; logic [31:0] d; logic r; bit a, h, t;
    logic [31:0] rd;
    rd = $urandom;
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, TMO, rd, 0, 1'b0, s, l, d, r, a, h, t);
    check_txn("ack_at_limit", 1'b0, TMO, rd, s, l, d, r, a, h, t);
  endtask

  task automatic test_spurious();
    int s, l; logic [31:0] d; logic r; bit a, h, t;
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 10, 1'b1, s, l, d, r, a, h, t);
    check_txn("spurious_ack", 1'b0, 1, 32'hA5A5_5A5A, s, l, d, r, a, h, t);
  endtask

  task automatic test_idle_ack();
    logic [31:0] prev;
    prev = rsp_dat;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h5555_AAAA;
    tick();
    tick();
    wbm_ack_i = 1'b0;
    checks++;
    if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_dat !== prev) begin
      errors++;
      $display("FAIL idle_ack: cyc=%0b rv=%0b rdy=%0b rd=%h, required 0/0/1/%h",
               wbm_cyc_o, rsp_valid, cmd_ready, rsp_dat, prev);
    end
  endtask

  task automatic test_back_to_back();
    int s, l; logic [31:0] d; logic r; bit a, h, t;
    for (int k = 0; k < 3; k++) begin
      do_txn(1'b1, 32'h4000_0000 + 32'(k * 4), $urandom, 4'hF, 1, 32'h0, 0, 1'b0, s, l, d, r, a, h, t);
      check_txn("back_to_back", 1'b1, 1, 32'h0, s, l, d, r, a, h, t);
    end
  endtask

  task automatic test_reset_mid_bus();
    int s, l; logic [31:0] d; logic r; bit a, h, t;
    bit stray;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0030; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (wbm_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL midbus_pre: stb=%0b, required 1", wbm_stb_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midbus_async_drop: cyc=%0b stb=%0b rv=%0b, required 0/0/0", wbm_cyc_o, wbm_stb_o, rsp_valid);
    end
    #2;
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL midbus_no_response: stray activity=%0b, required 0", stray);
    end
    do_txn(1'b0, 32'h3000_0034, 32'h0, 4'hF, 3, 32'h0BAD_F00D, 1, 1'b0, s, l, d, r, a, h, t);
    check_txn("after_reset", 1'b0, 3, 32'h0BAD_F00D, s, l, d, r, a, h, t);
  endtask

  task automatic test_random();
    int s, l; logic [31:0] d; logic r; bit a, h, t;
    logic        we;
    logic [31:0] adr, dat, rd;
    logic [3:0]  sel;
    int          ack_at, dly;
    for (int n = 0; n < 30; n++) begin
      we = 1'($urandom); adr = $urandom; dat = $urandom; rd = $urandom; sel = 4'($urandom);
      ack_at = int'($urandom_range(20, 0));
      dly = int'($urandom_range(3, 0));
      do_txn(we, adr, dat, sel, ack_at, rd, dly, 1'b0, s, l, d, r, a, h, t);
      check_txn("random", we, ack_at, rd, s, l, d, r, a, h, t);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_limit();
    test_spurious();
    test_idle_ack();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
